// File: rtl/frog_motion_ctrl.sv
// frog_motion_ctrl: Frogger frog movement controller.
// Hops one STEP per key press, drifts with the carrier under the frog,
// fills home slots at the top row, and runs the death/respawn sequence.
// Ports:
//   clk, Reset_n      system clock, asynchronous active-low reset
//   hard_clear        synchronous: clear homes, respawn at start
//   keycode[7:0]      keyboard code (edge-detected internally)
//   drift_speed[3:0]  carrier drift rate (0 = none, >9 saturates to 9)
//   drift_right       drift direction (1 = +X)
//   hazard            collision/water level from collision logic
//   frogX, frogY      frog position
//   direction[2:0]    facing: 000 up, 010 left, 100 down, 110 right
//   hopping, dead     state flags
//   home_mask         filled home slots
//   home_evt, death_evt, all_home   one-clock event pulses
module frog_motion_ctrl #(
    parameter int unsigned STEP          = 35,
    parameter int unsigned X_MIN         = 74,
    parameter int unsigned X_MAX         = 594,
    parameter int unsigned Y_MIN         = 60,
    parameter int unsigned Y_MAX         = 439,
    parameter int unsigned X_START       = 320,
    parameter int unsigned Y_START       = 428,
    parameter int unsigned NUM_HOMES     = 5,
    parameter int unsigned HOME_X0       = 100,
    parameter int unsigned HOME_PITCH    = 110,
    parameter int unsigned HOME_WIN      = 40,
    parameter int unsigned DIV_BASE      = 500000,
    parameter int unsigned DIV_STEP      = 50000,
    parameter int unsigned HOP_TICKS     = 4,
    parameter int unsigned RESPAWN_TICKS = 32
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 hard_clear,
    input  logic [7:0]           keycode,
    input  logic [3:0]           drift_speed,
    input  logic                 drift_right,
    input  logic                 hazard,
    output logic [9:0]           frogX,
    output logic [9:0]           frogY,
    output logic [2:0]           direction,
    output logic                 hopping,
    output logic                 dead,
    output logic [NUM_HOMES-1:0] home_mask,
    output logic                 home_evt,
    output logic                 death_evt,
    output logic                 all_home
);

    typedef enum logic [1:0] {ST_ALIVE, ST_HOP, ST_DEAD, ST_HOME_PAUSE} state_t;

    // Limits pre-folded so that the 11-bit compares never wrap.
    localparam logic [10:0] LEFT_LIM  = 11'(X_MIN + STEP);
    localparam logic [10:0] UP_LIM    = 11'(Y_MIN + STEP);
    localparam logic [10:0] X_MIN11   = 11'(X_MIN);
    localparam logic [10:0] X_MAX11   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);
    localparam logic [10:0] STEP11    = 11'(STEP);
    localparam logic [9:0]  STEP10    = 10'(STEP);
    localparam logic [9:0]  X_START10 = 10'(X_START);
    localparam logic [9:0]  Y_START10 = 10'(Y_START);
    localparam logic [19:0] DIV_BASE20 = 20'(DIV_BASE);
    localparam logic [19:0] DIV_STEP20 = 20'(DIV_STEP);
    localparam logic [15:0] HOP_CNT   = 16'(HOP_TICKS);
    localparam logic [15:0] RESP_CNT  = 16'(RESPAWN_TICKS);

    state_t                state_q, state_d;
    logic [9:0]            x_q, x_d, y_q, y_d;
    logic [2:0]            dir_q, dir_d;
    logic [NUM_HOMES-1:0]  home_q, home_d;
    logic                  home_evt_q, home_evt_d;
    logic                  death_evt_q, death_evt_d;
    logic                  all_home_q, all_home_d;
    logic [19:0]           div_q, div_d;
    logic [7:0]            prev_key_q, prev_key_d;
    logic [15:0]           tcnt_q, tcnt_d;

    logic [3:0]            spd_sat;
    logic [19:0]           term;
    logic                  tick;
    logic                  key_evt;
    logic [10:0]           x11, y11;
    logic [NUM_HOMES-1:0]  home_sel;
    logic                  home_found;
    logic                  drift_on, drift_oob;
    logic [9:0]            drift_x;
    logic                  moved;

    assign spd_sat  = (drift_speed > 4'd9) ? 4'd9 : drift_speed;
    assign term     = DIV_BASE20 - DIV_STEP20 * {16'd0, spd_sat};
    // >= rather than == so a speed change that lowers the terminal below the
    // running count restarts the period instead of waiting for a 20-bit wrap.
    assign tick     = (div_q >= term);
    assign key_evt  = (keycode != prev_key_q);
    assign x11      = {1'b0, x_q};
    assign y11      = {1'b0, y_q};
    assign drift_on  = (drift_speed != 4'd0);
    assign drift_oob = drift_right ? (x11 >= X_MAX11) : (x11 <= X_MIN11);
    assign drift_x   = drift_right ? (x_q + 10'd1) : (x_q - 10'd1);

    // Lowest empty home whose window strictly contains X.
    always_comb begin
        home_sel   = '0;
        home_found = 1'b0;
        for (int unsigned i = 0; i < NUM_HOMES; i++) begin
            if (!home_found && !home_q[i] &&
                x11 > 11'(HOME_X0 + i * HOME_PITCH) &&
                x11 < 11'(HOME_X0 + i * HOME_PITCH + HOME_WIN)) begin
                home_sel[i] = 1'b1;
                home_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        home_d      = home_q;
        tcnt_d      = tcnt_q;
        home_evt_d  = 1'b0;
        death_evt_d = 1'b0;
        all_home_d  = 1'b0;
        div_d       = tick ? '0 : div_q + 20'd1;
        prev_key_d  = keycode;
        moved       = 1'b0;

        if (hard_clear) begin
            home_d  = '0;
            x_d     = X_START10;
            y_d     = Y_START10;
            dir_d   = 3'b000;
            state_d = ST_ALIVE;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (hazard) begin
                        state_d     = ST_DEAD;
                        death_evt_d = 1'b1;
                        tcnt_d      = '0;
                    end else begin
                        if (key_evt) begin
                            case (keycode)
                                8'h04: if (x11 > LEFT_LIM) begin
                                    x_d = x_q - STEP10; dir_d = 3'b010; moved = 1'b1;
                                end
                                8'h07: if (x11 + STEP11 < X_MAX11) begin
                                    x_d = x_q + STEP10; dir_d = 3'b110; moved = 1'b1;
                                end
                                8'h16: if (y11 + STEP11 < Y_MAX11) begin
                                    y_d = y_q + STEP10; dir_d = 3'b100; moved = 1'b1;
                                end
                                8'h1A: if (y11 > UP_LIM) begin
                                    y_d = y_q - STEP10; dir_d = 3'b000; moved = 1'b1;
                                end else if (home_found) begin
                                    y_d        = y_q - STEP10;
                                    dir_d      = 3'b000;
                                    home_d     = home_q | home_sel;
                                    home_evt_d = 1'b1;
                                    moved      = 1'b1;
                                end
                                default: ;
                            endcase
                            if (moved) begin
                                state_d = home_evt_d ? ST_HOME_PAUSE : ST_HOP;
                                tcnt_d  = '0;
                            end
                        end
                        // An accepted move consumes this tick's drift.
                        if (!moved && tick && drift_on) begin
                            if (drift_oob) begin
                                state_d     = ST_DEAD;
                                death_evt_d = 1'b1;
                                tcnt_d      = '0;
                            end else begin
                                x_d = drift_x;
                            end
                        end
                    end
                end
                ST_HOP: begin
                    if (hazard) begin
                        state_d     = ST_DEAD;
                        death_evt_d = 1'b1;
                        tcnt_d      = '0;
                    end else if (tick) begin
                        if (drift_on && drift_oob) begin
                            state_d     = ST_DEAD;
                            death_evt_d = 1'b1;
                            tcnt_d      = '0;
                        end else begin
                            if (drift_on) x_d = drift_x;
                            if (tcnt_q + 16'd1 >= HOP_CNT) begin
                                state_d = ST_ALIVE;
                                tcnt_d  = '0;
                            end else begin
                                tcnt_d = tcnt_q + 16'd1;
                            end
                        end
                    end
                end
                ST_DEAD, ST_HOME_PAUSE: begin
                    if (state_q == ST_HOME_PAUSE && (&home_q)) begin
                        home_d     = '0;
                        all_home_d = 1'b1;
                    end
                    if (tick) begin
                        if (tcnt_q + 16'd1 >= RESP_CNT) begin
                            x_d     = X_START10;
                            y_d     = Y_START10;
                            dir_d   = 3'b000;
                            state_d = ST_ALIVE;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = ST_ALIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_ALIVE;
            x_q         <= X_START10;
            y_q         <= Y_START10;
            dir_q       <= 3'b000;
            home_q      <= '0;
            home_evt_q  <= 1'b0;
            death_evt_q <= 1'b0;
            all_home_q  <= 1'b0;
            div_q       <= '0;
            prev_key_q  <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            home_q      <= home_d;
            home_evt_q  <= home_evt_d;
            death_evt_q <= death_evt_d;
            all_home_q  <= all_home_d;
            div_q       <= div_d;
            prev_key_q  <= prev_key_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign frogX     = x_q;
    assign frogY     = y_q;
    assign direction = dir_q;
    assign hopping   = (state_q == ST_HOP);
    assign dead      = (state_q == ST_DEAD);
    assign home_mask = home_q;
    assign home_evt  = home_evt_q;
    assign death_evt = death_evt_q;
    assign all_home  = all_home_q;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
module tb_frog_motion_ctrl;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       hard_clear = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [3:0] drift_speed = 4'd0;
    logic       drift_right = 1'b0;
    logic       hazard = 1'b0;
    logic [9:0] frogX, frogY;
    logic [2:0] direction;
    logic       hopping, dead;
    logic [4:0] home_mask;
    logic       home_evt, death_evt, all_home;

    int checks = 0;
    int errors = 0;
    int tb_div = 0;
    int ticks_total = 0;

    always #5 clk = ~clk;

    frog_motion_ctrl #(
        .DIV_BASE (12),
        .DIV_STEP (1)
    ) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .hard_clear  (hard_clear),
        .keycode     (keycode),
        .drift_speed (drift_speed),
        .drift_right (drift_right),
        .hazard      (hazard),
        .frogX       (frogX),
        .frogY       (frogY),
        .direction   (direction),
        .hopping     (hopping),
        .dead        (dead),
        .home_mask   (home_mask),
        .home_evt    (home_evt),
        .death_evt   (death_evt),
        .all_home    (all_home)
    );

    // Reference tick timing: terminal 12 - min(speed,9), period terminal+1.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tb_div <= 0;
        end else if (tb_div == 12 - ((drift_speed > 4'd9) ? 9 : int'(drift_speed))) begin
            tb_div      <= 0;
            ticks_total <= ticks_total + 1;
        end else begin
            tb_div <= tb_div + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        Reset_n = 1'b0; keycode = 8'h00; hazard = 1'b0; hard_clear = 1'b0;
        drift_speed = 4'd0; drift_right = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
    endtask

    task automatic press(input logic [7:0] k, output bit ok);
        int n;
        @(negedge clk); keycode = k;
        @(negedge clk); keycode = 8'h00;
        n = 0;
        while (hopping && n < 200) begin @(negedge clk); n++; end
        ok = (n < 200);
    endtask

    task automatic press_n(input logic [7:0] k, input int cnt, output bit ok);
        bit o;
        ok = 1'b1;
        for (int i = 0; i < cnt; i++) begin press(k, o); ok &= o; end
    endtask

    task automatic fill_home(input logic [7:0] k, input int cnt, output bit ok);
        bit o1, o2;
        int n;
        press_n(k, cnt, o1);
        press_n(8'h1A, 11, o2);
        n = 0;
        while (frogY != 10'd428 && n < 1000) begin @(negedge clk); n++; end
        ok = o1 && o2 && (n < 1000);
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({frogX, frogY, direction, hopping, dead, home_mask, home_evt, death_evt, all_home} !==
            {10'd320, 10'd428, 3'b000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got x=%0d y=%0d dir=%b hop=%b dead=%b mask=%b ev=%b%b%b exp 320/428/000/0/0/00000/000",
                     frogX, frogY, direction, hopping, dead, home_mask, home_evt, death_evt, all_home);
        end
        do_reset();
    endtask

    task automatic test_hop();
        int snap, n;
        bit ok;
        do_reset();
        @(negedge clk); keycode = 8'h1A;
        @(negedge clk);
        checks++;
        if ({frogY, direction, hopping} !== {10'd393, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL hop_up got y=%0d dir=%b hop=%b exp 393/000/1", frogY, direction, hopping);
        end
        snap = ticks_total;
        keycode = 8'h00;
        @(negedge clk); keycode = 8'h1A;
        n = 0;
        while (hopping && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (ticks_total - snap !== 4) begin
            errors++;
            $display("FAIL hop_len got %0d ticks exp 4", ticks_total - snap);
        end
        checks++;
        if (frogY !== 10'd393) begin
            errors++;
            $display("FAIL hop_lockout got y=%0d exp 393", frogY);
        end
        press(8'h04, ok);
        checks++;
        if ({ok, frogX, frogY, direction} !== {1'b1, 10'd285, 10'd393, 3'b010}) begin
            errors++;
            $display("FAIL hop_left got ok=%b x=%0d y=%0d dir=%b exp 1/285/393/010", ok, frogX, frogY, direction);
        end
        press(8'h16, ok);
        checks++;
        if ({ok, frogX, frogY, direction} !== {1'b1, 10'd285, 10'd428, 3'b100}) begin
            errors++;
            $display("FAIL hop_down got ok=%b x=%0d y=%0d dir=%b exp 1/285/428/100", ok, frogX, frogY, direction);
        end
        press(8'h04, ok);
        press(8'h16, ok);
        checks++;
        if ({frogX, frogY, direction, hopping} !== {10'd250, 10'd428, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL down_blocked got x=%0d y=%0d dir=%b hop=%b exp 250/428/010/0", frogX, frogY, direction, hopping);
        end
        press(8'h07, ok);
        checks++;
        if ({frogX, direction} !== {10'd285, 3'b110}) begin
            errors++;
            $display("FAIL hop_right got x=%0d dir=%b exp 285/110", frogX, direction);
        end
    endtask

    task automatic test_homes();
        int snap, n;
        bit ok, o;
        do_reset();
        press_n(8'h04, 6, ok);
        press_n(8'h1A, 10, o); ok &= o;
        @(negedge clk); keycode = 8'h1A;
        @(negedge clk);
        checks++;
        if ({ok, frogX, frogY, home_mask, home_evt} !== {1'b1, 10'd110, 10'd43, 5'b00001, 1'b1}) begin
            errors++;
            $display("FAIL home0_entry got ok=%b x=%0d y=%0d mask=%b evt=%b exp 1/110/43/00001/1",
                     ok, frogX, frogY, home_mask, home_evt);
        end
        snap = ticks_total;
        keycode = 8'h00;
        @(negedge clk);
        checks++;
        if (home_evt !== 1'b0) begin
            errors++;
            $display("FAIL home_evt_width got %b exp 0", home_evt);
        end
        n = 0;
        while (frogY != 10'd428 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (ticks_total - snap !== 32) begin
            errors++;
            $display("FAIL home_pause_len got %0d ticks exp 32", ticks_total - snap);
        end
        checks++;
        if ({frogX, frogY, direction, home_mask} !== {10'd320, 10'd428, 3'b000, 5'b00001}) begin
            errors++;
            $display("FAIL home_respawn got x=%0d y=%0d dir=%b mask=%b exp 320/428/000/00001",
                     frogX, frogY, direction, home_mask);
        end
        fill_home(8'h04, 3, ok);
        fill_home(8'h07, 1, o); ok &= o;
        fill_home(8'h07, 4, o); ok &= o;
        checks++;
        if ({ok, home_mask} !== {1'b1, 5'b01111}) begin
            errors++;
            $display("FAIL homes_123 got ok=%b mask=%b exp 1/01111", ok, home_mask);
        end
        press_n(8'h04, 6, ok);
        press_n(8'h1A, 11, o); ok &= o;
        repeat (3) @(negedge clk);
        checks++;
        if ({ok, frogX, frogY, direction, home_mask, hopping, home_evt} !==
            {1'b1, 10'd110, 10'd78, 3'b000, 5'b01111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL home_full_blocked got ok=%b x=%0d y=%0d dir=%b mask=%b hop=%b evt=%b exp 1/110/78/000/01111/0/0",
                     ok, frogX, frogY, direction, home_mask, hopping, home_evt);
        end
        press_n(8'h07, 13, ok);
        @(negedge clk); keycode = 8'h1A;
        @(negedge clk);
        checks++;
        if ({ok, frogX, home_mask, home_evt, all_home} !== {1'b1, 10'd565, 5'b11111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL home4_entry got ok=%b x=%0d mask=%b evt=%b all=%b exp 1/565/11111/1/0",
                     ok, frogX, home_mask, home_evt, all_home);
        end
        keycode = 8'h00;
        @(negedge clk);
        checks++;
        if ({home_mask, home_evt, all_home} !== {5'b00000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL all_home_clear got mask=%b evt=%b all=%b exp 00000/0/1", home_mask, home_evt, all_home);
        end
        @(negedge clk);
        checks++;
        if ({all_home, frogY} !== {1'b0, 10'd43}) begin
            errors++;
            $display("FAIL all_home_width got all=%b y=%0d exp 0/43", all_home, frogY);
        end
    endtask

    task automatic test_drift();
        int n;
        bit ok;
        do_reset();
        press_n(8'h07, 7, ok);
        n = 0;
        while (tb_div != 0 && n < 50) begin @(negedge clk); n++; end
        drift_speed = 4'd3; drift_right = 1'b1;
        n = 0;
        while (frogX == 10'd565 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if ({ok, frogX} !== {1'b1, 10'd566} || n !== 10) begin
            errors++;
            $display("FAIL drift_first got ok=%b x=%0d after %0d clks exp 1/566 after 10", ok, frogX, n);
        end
        n = 0;
        while (frogX != 10'd594 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if ({frogX, dead} !== {10'd594, 1'b0}) begin
            errors++;
            $display("FAIL drift_edge got x=%0d dead=%b exp 594/0", frogX, dead);
        end
        n = 0;
        while (!death_evt && n < 50) begin @(negedge clk); n++; end
        checks++;
        if ({frogX, dead, death_evt} !== {10'd594, 1'b1, 1'b1} || n !== 10) begin
            errors++;
            $display("FAIL drift_death got x=%0d dead=%b evt=%b after %0d clks exp 594/1/1 after 10",
                     frogX, dead, death_evt, n);
        end
        drift_speed = 4'd0;
        @(negedge clk);
        checks++;
        if ({death_evt, frogX} !== {1'b0, 10'd594}) begin
            errors++;
            $display("FAIL death_evt_width got evt=%b x=%0d exp 0/594", death_evt, frogX);
        end
        n = 0;
        while (dead && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if ({dead, frogX, frogY, direction} !== {1'b0, 10'd320, 10'd428, 3'b000}) begin
            errors++;
            $display("FAIL drift_respawn got dead=%b x=%0d y=%0d dir=%b exp 0/320/428/000", dead, frogX, frogY, direction);
        end
    endtask

    task automatic test_hazard();
        int snap, n;
        do_reset();
        @(negedge clk); hazard = 1'b1; keycode = 8'h07;
        @(negedge clk);
        checks++;
        if ({dead, death_evt, hopping, frogX, direction} !== {1'b1, 1'b1, 1'b0, 10'd320, 3'b000}) begin
            errors++;
            $display("FAIL hazard_priority got dead=%b evt=%b hop=%b x=%0d dir=%b exp 1/1/0/320/000",
                     dead, death_evt, hopping, frogX, direction);
        end
        snap = ticks_total;
        hazard = 1'b0; keycode = 8'h00;
        @(negedge clk);
        checks++;
        if ({death_evt, dead} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hazard_evt_width got evt=%b dead=%b exp 0/1", death_evt, dead);
        end
        n = 0;
        while (dead && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (ticks_total - snap !== 32) begin
            errors++;
            $display("FAIL dead_len got %0d ticks exp 32", ticks_total - snap);
        end
        checks++;
        if ({dead, frogX, frogY, direction} !== {1'b0, 10'd320, 10'd428, 3'b000}) begin
            errors++;
            $display("FAIL hazard_respawn got dead=%b x=%0d y=%0d dir=%b exp 0/320/428/000", dead, frogX, frogY, direction);
        end
    endtask

    task automatic test_aborts();
        bit ok, o;
        do_reset();
        press(8'h07, ok);
        press_n(8'h1A, 11, o); ok &= o;
        repeat (5) @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({ok, frogX, frogY, direction, home_mask, hopping, dead} !==
            {1'b1, 10'd320, 10'd428, 3'b000, 5'b00000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_pause got ok=%b x=%0d y=%0d dir=%b mask=%b hop=%b dead=%b exp 1/320/428/000/00000/0/0",
                     ok, frogX, frogY, direction, home_mask, hopping, dead);
        end
        @(negedge clk); Reset_n = 1'b1;
        fill_home(8'h07, 1, ok);
        checks++;
        if ({ok, home_mask} !== {1'b1, 5'b00100}) begin
            errors++;
            $display("FAIL home2_fill got ok=%b mask=%b exp 1/00100", ok, home_mask);
        end
        @(negedge clk); keycode = 8'h04;
        @(negedge clk);
        keycode = 8'h00; hard_clear = 1'b1;
        @(negedge clk);
        hard_clear = 1'b0;
        checks++;
        if ({frogX, frogY, direction, home_mask, hopping, dead} !==
            {10'd320, 10'd428, 3'b000, 5'b00000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hard_clear_in_hop got x=%0d y=%0d dir=%b mask=%b hop=%b dead=%b exp 320/428/000/00000/0/0",
                     frogX, frogY, direction, home_mask, hopping, dead);
        end
    endtask

    initial begin
        test_reset();
        test_hop();
        test_homes();
        test_drift();
        test_hazard();
        test_aborts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_motion_ctrl.md
Name: frog_motion_ctrl

Overview:
- Parametrised frog movement controller for Frogger: hop-on-keypress on a STEP grid, log/turtle drift, NUM_HOMES home slots, death and respawn sequencing.
- Sits between the keyboard keycode source / collision logic and the sprite renderer and score/lives logic.
- Beyond the previous frog mover:
  - single synchronous clock domain with tick enables instead of derived clocks;
  - hop lock-out;
  - hazard-driven death with a timed respawn;
  - one-cycle event pulses;
  - a generic home count.

Parameters:
STEP, 35, hop distance in pixels
X_MIN, 74, left wall
X_MAX, 594, right wall
Y_MIN, 60, top wall
Y_MAX, 439, bottom wall
X_START, 320, respawn X
Y_START, 428, respawn Y
NUM_HOMES, 5, number of home slots (1..8)
HOME_X0, 100, left edge of home 0 window
HOME_PITCH, 110, spacing between home windows
HOME_WIN, 40, home window width
DIV_BASE, 500000, divider terminal count at drift_speed=0
DIV_STEP, 50000, terminal reduction per drift_speed unit
HOP_TICKS, 4, ticks of key lock-out after a hop
RESPAWN_TICKS, 32, ticks spent in DEAD or HOME_PAUSE

Ports:
clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
hard_clear  in  1  synchronous; clears home_mask, forces respawn
keycode  in  8  current keyboard keycode
drift_speed  in  4  drift rate of the carrier under the frog; 0 = none; values above 9 are treated as 9
drift_right  in  1  drift direction: 1 = +X, 0 = -X
hazard  in  1  collision/water hit from the collision logic, level
frogX  out  10  frog X position
frogY  out  10  frog Y position
direction  out  3  facing: 000 up, 010 left, 100 down, 110 right
hopping  out  1  state == HOP
dead  out  1  state == DEAD
home_mask  out  NUM_HOMES  filled homes
home_evt  out  1  one-cycle pulse when a home is filled
death_evt  out  1  one-cycle pulse on entering DEAD
all_home  out  1  one-cycle pulse when every home is filled

Behaviour:
- Reset (Reset_n=0, async) sets:
  - frogX=X_START, frogY=Y_START, direction=000;
  - state ALIVE, home_mask=0, all pulses 0;
  - divider=0, prev_keycode=0, tick counter=0.
- Divider:
  - 20-bit counter; terminal T = DIV_BASE - DIV_STEP*min(drift_speed,9).
  - When count==T: count<=0 and tick=1 for one clk. Tick period is T+1 clocks.
- Key edge:
  - prev_keycode<=keycode every clk.
  - A key event is keycode != prev_keycode, evaluated every clk in all states.
  - Events in HOP/DEAD/HOME_PAUSE are discarded, not queued.
- Moves, in ALIVE only. Bounds use 11-bit arithmetic, so no wrap-around.
  - 0x04: if X-STEP > X_MIN then X-=STEP, dir 010.
  - 0x07: if X+STEP < X_MAX then X+=STEP, dir 110.
  - 0x16: if Y+STEP < Y_MAX then Y+=STEP, dir 100.
  - 0x1A: if Y-STEP > Y_MIN then Y-=STEP, dir 000.
  - 0x1A at the top boundary, else-branch:
    - Take the lowest i with HOME_X0+i*HOME_PITCH < X < HOME_X0+i*HOME_PITCH+HOME_WIN and home_mask[i]==0.
    - Then Y-=STEP, dir 000, home_mask[i]<=1, home_evt pulse, state -> HOME_PAUSE.
  - A blocked move changes nothing, not even direction.
  - Other keycodes are ignored.
  - An accepted non-home move -> HOP, tick counter=0.
- HOP: counts ticks; after HOP_TICKS ticks -> ALIVE.
- Drift:
  - On each tick in ALIVE or HOP with drift_speed != 0, X±=1 per drift_right.
  - If the result would be < X_MIN or > X_MAX, X is held instead -> DEAD.
  - If a key move and a tick occur on the same clk, the key move is applied and that tick's drift is skipped.
- Hazard: hazard=1 in ALIVE or HOP -> DEAD on the next clk edge. Hazard takes priority over a simultaneous key or drift. Hazard is ignored in DEAD and HOME_PAUSE.
- DEAD:
  - death_evt pulses in the entry cycle; position is frozen.
  - After RESPAWN_TICKS ticks: X/Y = start, dir 000 -> ALIVE.
- HOME_PAUSE:
  - Same timing as DEAD, no death_evt.
  - If home_mask becomes all ones, the next clk gives home_mask<=0 and all_home pulses once, while the pause continues.
- hard_clear:
  - home_mask<=0; position/dir to start; state ALIVE; tick counter=0.
  - Priority above every other event except Reset_n.
- Reset_n asserted mid-HOP/DEAD/HOME_PAUSE aborts immediately to the reset values.
- Pulses (home_evt, death_evt, all_home) are exactly one clk wide and never overlap each other.

Test Plan:
- Reset, keycode 00->1A with no drift -> frogY 428->393, dir 000, hopping=1 for 4 ticks; a second 1A->00->1A inside HOP leaves Y at 393.
- Frog at X=110, Y=94 with homes empty, key 1A -> Y=59, home_mask=00001, home_evt one clk, HOME_PAUSE 32 ticks, then X=320, Y=428.
- home_mask=01111 and frog at X=550, Y=94, key 1A -> home_mask 11111, then next clk 00000 with all_home pulse; the same key at X=110 is blocked (home 0 full) and changes nothing.
- drift_speed=3, drift_right=1, X=592 -> each tick every 350001 clks X+1; at X=594 the next tick gives death_evt, dead=1, X held at 594.
- hazard=1 on the same clk as a key 07 event in ALIVE -> DEAD, X unchanged, death_evt one clk; after 32 ticks, respawn at 320/428.
- Reset_n=0 during HOME_PAUSE and hard_clear during HOP -> both return to 320/428, dir 000, ALIVE; hard_clear also clears home_mask to 0.
